// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared coin values, prices and payout types for the vending datapath
package vending_pkg;

    localparam logic [7:0] COIN_CIEN = 8'd1;
    localparam logic [7:0] COIN_QUIN = 8'd5;

    localparam int unsigned DEF_MAX_CREDIT = 20;
    localparam int unsigned DEF_PRICE_E    = 3;
    localparam int unsigned DEF_PRICE_L    = 4;
    localparam int unsigned DEF_PRICE_X    = 5;
    localparam int unsigned DEF_PRICE_M    = 7;
    localparam int unsigned DEF_COIN_GAP   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        Q,
        C,
        GAP,
        DONE
    } payout_state_t;

    typedef enum logic [1:0] {
        REQ_CANCEL,
        REQ_SALE,
        REQ_RETURN
    } req_kind_t;

    // Largest coin first so change uses the fewest coins.
    function automatic payout_state_t next_coin_state(input logic [7:0] rest);
        if (rest >= COIN_QUIN) begin
            return Q;
        end else if (rest >= COIN_CIEN) begin
            return C;
        end
        return DONE;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/credit_changer.sv
// rtl/credit_changer.sv - credit accumulator and change dispenser for the coffee vending machine
module credit_changer
    import vending_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int unsigned PRICE_E    = DEF_PRICE_E,
    parameter int unsigned PRICE_L    = DEF_PRICE_L,
    parameter int unsigned PRICE_X    = DEF_PRICE_X,
    parameter int unsigned PRICE_M    = DEF_PRICE_M,
    parameter int unsigned COIN_GAP   = DEF_COIN_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_cien,
    input  logic       en_quin,
    input  logic       vuelto,
    input  logic       producto,
    input  logic       rst_cuenta,
    input  logic [7:0] valor_producto,
    output logic       m0,
    output logic       m1,
    output logic       m2,
    output logic       m3,
    output logic       m4,
    output logic       sal_cien,
    output logic       sal_quin,
    output logic [7:0] credito,
    output logic       busy,
    output logic       listo,
    output logic       err
);

    localparam int GAP_W = $clog2(COIN_GAP + 1);

    logic rise_cien;
    logic rise_quin;
    logic rise_vuelto;
    logic rise_cancel;

    rise_detect u_rise_cien (.clk(clk), .rst(rst), .din(en_cien),    .rise(rise_cien));
    rise_detect u_rise_quin (.clk(clk), .rst(rst), .din(en_quin),    .rise(rise_quin));
    rise_detect u_rise_vuel (.clk(clk), .rst(rst), .din(vuelto),     .rise(rise_vuelto));
    rise_detect u_rise_canc (.clk(clk), .rst(rst), .din(rst_cuenta), .rise(rise_cancel));

    payout_state_t    state;
    payout_state_t    state_next;
    logic [7:0]       rest;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_last;

    logic       pend_valid;
    logic       pend_quin;
    logic       ret_pend;

    logic [7:0] cv;
    logic [8:0] credit_sum;
    logic       coin_edge;
    logic       coin_accept;
    logic       coin_reject;
    logic       sale_short;

    logic       req_valid;
    req_kind_t  req_kind;
    logic [7:0] amount;

    always_comb begin
        cv = 8'd0;
        if (en_cien) begin
            cv = COIN_CIEN;
        end else if (en_quin) begin
            cv = COIN_QUIN;
        end
    end

    assign busy       = (state != IDLE);
    assign credit_sum = {1'b0, credito} + {1'b0, cv};
    assign m0         = busy | (credit_sum > 9'(MAX_CREDIT));
    assign m1         = (credito >= 8'(PRICE_E));
    assign m2         = (credito >= 8'(PRICE_L));
    assign m3         = (credito >= 8'(PRICE_X));
    assign m4         = (credito >= 8'(PRICE_M));

    // The 100 coin wins when both enables are up, so only its edge counts then.
    assign coin_edge   = en_cien ? rise_cien : (en_quin & rise_quin);
    assign coin_accept = coin_edge & ~m0;
    assign coin_reject = coin_edge & m0;
    assign sale_short  = (valor_producto > credito);
    assign gap_last    = (gap_cnt == GAP_W'(COIN_GAP - 1));

    always_comb begin
        req_valid = 1'b0;
        req_kind  = REQ_RETURN;
        amount    = 8'd0;
        if (!busy) begin
            if (rise_cancel) begin
                req_valid = 1'b1;
                req_kind  = REQ_CANCEL;
                amount    = credito;
            end else if (rise_vuelto && producto) begin
                req_valid = 1'b1;
                req_kind  = REQ_SALE;
                amount    = sale_short ? 8'd0 : (credito - valor_producto);
            end else if (((rise_vuelto && !producto) || ret_pend) && pend_valid) begin
                req_valid = 1'b1;
                req_kind  = REQ_RETURN;
                amount    = pend_quin ? COIN_QUIN : COIN_CIEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credito    <= 8'd0;
            err        <= 1'b0;
            pend_valid <= 1'b0;
            pend_quin  <= 1'b0;
            ret_pend   <= 1'b0;
        end else begin
            if (req_valid && req_kind != REQ_RETURN) begin
                credito <= 8'd0;
            end else if (coin_accept) begin
                credito <= credito + cv;
            end

            if (req_valid && req_kind == REQ_SALE && sale_short) begin
                err <= 1'b1;
            end

            if (coin_reject) begin
                pend_valid <= 1'b1;
                pend_quin  <= ~en_cien;
            end else if (req_valid && req_kind == REQ_RETURN) begin
                pend_valid <= 1'b0;
            end

            // A return asked for mid-payout is remembered and taken once back in IDLE.
            if (busy && rise_vuelto && !producto) begin
                ret_pend <= 1'b1;
            end else if (!busy) begin
                ret_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rest    <= 8'd0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (req_valid) begin
                        rest <= amount;
                    end
                end
                Q:       rest <= rest - COIN_QUIN;
                C:       rest <= rest - COIN_CIEN;
                GAP:     gap_cnt <= gap_last ? '0 : gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        sal_quin   = 1'b0;
        sal_cien   = 1'b0;
        listo      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = next_coin_state(rest);
            Q: begin
                sal_quin   = 1'b1;
                state_next = GAP;
            end
            C: begin
                sal_cien   = 1'b1;
                state_next = GAP;
            end
            GAP: begin
                if (gap_last) begin
                    state_next = next_coin_state(rest);
                end
            end
            DONE: begin
                listo      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_credit_changer.sv
// tb/tb_credit_changer.sv - directed scoreboard bench for credit_changer
module tb_credit_changer;

    localparam int K_QUIN  = 0;
    localparam int K_CIEN  = 1;
    localparam int K_LISTO = 2;
    localparam int COIN_T  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_cien = 1'b0;
    logic       en_quin = 1'b0;
    logic       vuelto = 1'b0;
    logic       producto = 1'b0;
    logic       rst_cuenta = 1'b0;
    logic [7:0] valor_producto = 8'd0;
    logic       m0, m1, m2, m3, m4;
    logic       sal_cien, sal_quin;
    logic [7:0] credito;
    logic       busy, listo, err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];

    credit_changer dut (
        .clk(clk), .rst(rst), .en_cien(en_cien), .en_quin(en_quin),
        .vuelto(vuelto), .producto(producto), .rst_cuenta(rst_cuenta),
        .valor_producto(valor_producto),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3), .m4(m4),
        .sal_cien(sal_cien), .sal_quin(sal_quin), .credito(credito),
        .busy(busy), .listo(listo), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sal_quin || sal_cien || listo) begin
            int   got;
            ev_t  ev;
            got = sal_quin ? K_QUIN : (sal_cien ? K_CIEN : K_LISTO);
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_pulse kind=%0d cycle=%0d expected none", got, cyc);
            end
            if (exp_q.size() != 0) begin
                ev = exp_q.pop_front();
                tests++;
                assert (got === ev.kind && cyc === ev.at) else begin
                    fails++;
                    $error("FAIL pulse kind=%0d cycle=%0d expected kind=%0d cycle=%0d",
                           got, cyc, ev.kind, ev.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic coin(input bit quin);
        if (quin) en_quin = 1'b1; else en_cien = 1'b1;
        tick(1);
        en_quin = 1'b0;
        en_cien = 1'b0;
        tick(1);
    endtask

    // Fewest coins: 500s first, each coin 1+COIN_GAP cycles, listo after the last gap.
    task automatic expect_payout(input int n, input int nq, input int nc);
        for (int i = 0; i < nq; i++) exp_q.push_back('{K_QUIN, n + 2 + COIN_T * i});
        for (int j = 0; j < nc; j++) exp_q.push_back('{K_CIEN, n + 2 + COIN_T * (nq + j)});
        exp_q.push_back('{K_LISTO, n + 2 + COIN_T * (nq + nc)});
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
        tick(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(3);
        rst = 1'b0;
        check("rst_credito", credito, 0);
        check("rst_flags", {m0, m1, m2, m3, m4, busy, listo, err}, 0);
        check("rst_eject", {sal_quin, sal_cien}, 0);

        // 500 + 100 = 6, then price 4 sale pays two 100s
        coin(1'b1);
        check("credit_5", credito, 5);
        coin(1'b0);
        check("credit_6", credito, 6);
        check("m4321_at6", {m4, m3, m2, m1}, 4'b0111);
        valor_producto = 8'd4;
        producto = 1'b1;
        vuelto = 1'b1;
        n = cyc;
        expect_payout(n, 0, 2);
        tick(1);
        vuelto = 1'b0;
        check("busy_sale", busy, 1);
        drain("sale_drain", 60);
        check("sale_credito", credito, 0);
        check("sale_err", err, 0);

        // credit 18, rejected 500 is returned on its own
        coin(1'b1); coin(1'b1); coin(1'b1);
        coin(1'b0); coin(1'b0); coin(1'b0);
        check("credit_18", credito, 18);
        check("m4321_at18", {m4, m3, m2, m1}, 4'b1111);
        en_quin = 1'b1;
        #1;
        check("m0_over", m0, 1);
        tick(1);
        en_quin = 1'b0;
        check("reject_credito", credito, 18);
        tick(1);
        producto = 1'b0;
        vuelto = 1'b1;
        n = cyc;
        expect_payout(n, 1, 0);
        tick(1);
        vuelto = 1'b0;
        drain("return_drain", 40);
        check("return_credito", credito, 18);

        // fill to exactly MAX, next 100 rejected; cancel refunds 20 as four 500s
        coin(1'b0); coin(1'b0);
        check("credit_max", credito, 20);
        en_cien = 1'b1;
        #1;
        check("m0_at_max", m0, 1);
        tick(1);
        en_cien = 1'b0;
        tick(1);
        check("max_hold", credito, 20);
        rst_cuenta = 1'b1;
        n = cyc;
        expect_payout(n, 4, 0);
        tick(1);
        rst_cuenta = 1'b0;
        drain("cancel20_drain", 60);
        check("cancel20_credito", credito, 0);
        vuelto = 1'b1;
        n = cyc;
        expect_payout(n, 0, 1);
        tick(1);
        vuelto = 1'b0;
        drain("ret100_drain", 40);
        // nothing pending now: a return is a no-op
        vuelto = 1'b1;
        tick(1);
        vuelto = 1'b0;
        check("noop_busy", busy, 0);
        tick(10);

        // credit 12 cancel: two 500s then two 100s
        coin(1'b1); coin(1'b1); coin(1'b0); coin(1'b0);
        check("credit_12", credito, 12);
        rst_cuenta = 1'b1;
        n = cyc;
        expect_payout(n, 2, 2);
        tick(1);
        rst_cuenta = 1'b0;
        drain("cancel12_drain", 60);
        check("cancel12_credito", credito, 0);

        // price 7 with credit 3: zero payout, sticky err
        coin(1'b0); coin(1'b0); coin(1'b0);
        check("credit_3", credito, 3);
        valor_producto = 8'd7;
        producto = 1'b1;
        vuelto = 1'b1;
        n = cyc;
        expect_payout(n, 0, 0);
        tick(1);
        vuelto = 1'b0;
        drain("short_drain", 20);
        check("short_err", err, 1);
        check("short_credito", credito, 0);
        tick(10);
        check("err_sticky", err, 1);

        // vuelto held 50 cycles: one payout only
        coin(1'b1);
        valor_producto = 8'd3;
        vuelto = 1'b1;
        n = cyc;
        expect_payout(n, 0, 2);
        tick(50);
        vuelto = 1'b0;
        drain("hold_drain", 40);
        tick(10);
        check("hold_credito", credito, 0);

        // cancel beats sale in the same cycle: refund of 6, not change of 2
        coin(1'b1); coin(1'b0);
        valor_producto = 8'd4;
        vuelto = 1'b1;
        rst_cuenta = 1'b1;
        n = cyc;
        expect_payout(n, 1, 1);
        tick(1);
        vuelto = 1'b0;
        rst_cuenta = 1'b0;
        drain("prio_drain", 40);

        // rst in mid refund of 10 loses the rest of the payout
        coin(1'b1); coin(1'b1);
        check("credit_10", credito, 10);
        rst_cuenta = 1'b1;
        n = cyc;
        exp_q.push_back('{K_QUIN, n + 2});
        tick(1);
        rst_cuenta = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_credito", credito, 0);
        check("midrst_eject", {sal_quin, sal_cien, listo}, 0);
        check("midrst_err", err, 0);
        tick(30);
        check("midrst_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
